store_buffer: RTL and testbench
===============================

# store_buffer

Write-side counterpart of the MEM-stage load extractor. It accepts store requests (sb/sh/sw) from the pipeline and converts each into a word-aligned address, a byte-lane write enable and a lane-replicated write word. It queues the requests in a small FIFO and drains them to the data SRAM port through a request/accept handshake. It also reports word-address matches against queued stores, so the pipeline can stall a dependent load until the store has drained.

## Interface
- DEPTH, 2: number of buffer entries; power of two, ≥2.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- st_valid  input  1  store request present this cycle.
- st_ready  output  1  buffer can accept a request; equals !full.
- memW  input  3  store type: 3'b001 sb, 3'b010 sh, 3'b011 sw, anything else = no store.
- st_addr  input  32  byte address from ALU.
- st_data  input  32  rt register value.
- st_misalign  output  1  combinational; high when st_valid and the address is misaligned for memW.
- data_sram_en  output  1  head entry valid, write request to SRAM.
- data_sram_wen  output  4  byte-lane write enable.
- data_sram_addr  output  32  word-aligned address.
- data_sram_wdata  output  32  lane-replicated write data.
- data_sram_addr_ok  input  1  SRAM accepts the current request this cycle.
- ld_addr  input  32  address of the load currently in MEM.
- ld_hit  output  1  combinational; some valid entry has addr[31:2] == ld_addr[31:2].
- sb_empty  output  1  no valid entries.

## Operation
- Formatting at enqueue, with a = st_addr[1:0]:
  - sb: wen = 4'b0001 << a; wdata = {4{st_data[7:0]}}.
  - sh: wen = a[1] ? 4'b1100 : 4'b0011; wdata = {2{st_data[15:0]}}.
  - sw: wen = 4'b1111; wdata = st_data.
  - Stored address is always {st_addr[31:2], 2'b00}.
- Misalignment:
  - sh with a[0]=1, or sw with a≠0, sets st_misalign.
  - A misaligned request is consumed if st_ready and is never enqueued.
  - sb is never misaligned.
- Enqueue happens when st_valid & st_ready & memW is a store & aligned. A non-store memW with st_valid is ignored; st_misalign stays 0 for it.
- FIFO storage:
  - Each entry holds {addr[31:2], wen, wdata} plus a valid bit.
  - Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy counter runs 0..DEPTH.
- Drain:
  - data_sram_en = !empty; the head fields drive the SRAM outputs.
  - When data_sram_en & data_sram_addr_ok: pop the head and advance the head pointer.
  - When empty: en=0, wen=0, addr=0, wdata=0.
- Simultaneous push and pop:
  - Occupancy is unchanged and both pointers advance.
  - When full, st_ready=0 even if a pop occurs that cycle; there is no same-cycle bypass.
- ld_hit compares only entries already in the buffer, not the request being enqueued this cycle.
- Stores drain strictly in program order.

## Timing
- Reset (asynchronous):
  - Occupancy 0, pointers 0, all valid bits 0.
  - Outputs while and after reset: st_ready=1, sb_empty=1, data_sram_en=0, data_sram_wen=0, data_sram_addr=0, data_sram_wdata=0, ld_hit=0.
- Reset mid-operation discards all queued stores immediately; no partial SRAM write is issued after reset asserts.
- Latency: a request enqueued at edge N appears on data_sram_* from after edge N (visible in cycle N+1). The earliest pop is at edge N+1.
- Throughput: one store per cycle when data_sram_addr_ok is held high.
- Outputs hold stable while en=1 and addr_ok=0.
- Full: st_ready drops in the cycle after occupancy reaches DEPTH and rises in the cycle after a pop.
- st_misalign and ld_hit are combinational, with zero latency.

## Structure
- Shared package holds:
  - memW encodings: MEMW_SB=3'b001, MEMW_SH=3'b010, MEMW_SW=3'b011.
  - WEN_NONE=4'b0000 and WEN_ALL=4'b1111.
  - The memR load encodings, kept alongside so loads and stores share one definition.
- One sub-module, store_fmt: purely combinational lane formatter plus misalignment check (memW, addr, data → wen, wdata, misalign).
- FIFO, pointers and drain logic live in store_buffer.

## Test plan
- sb at 0x1000_0003 with data 0x1234_56AB → entry has addr 0x1000_0000, wen 4'b1000, wdata 0xABAB_ABAB; with addr_ok=1, en is high exactly one cycle, then sb_empty=1.
- sh at 0x0000_0042 with data 0xFFFF_BEEF → wen 4'b1100, wdata 0xBEEF_BEEF. sh at 0x41 and sw at 0x42 → st_misalign=1, no enqueue, sb_empty stays 1.
- addr_ok held 0 while three sw are issued (DEPTH=2) → st_ready=0 after two. Raise addr_ok → drains in order and st_ready returns; the third store is accepted and written last.
- Back-to-back sw every cycle with addr_ok=1 → one SRAM write per cycle, occupancy never exceeds 1, pointers wrap correctly over 8 stores.
- Queued sw to 0x2000_0004, ld_addr 0x2000_0006 → ld_hit=1. ld_addr 0x2000_0008 → ld_hit=0. After the drain, ld_hit=0 for 0x2000_0006.
- Two entries queued, reset pulsed mid-cycle → en, wen, addr and wdata go to 0 immediately, sb_empty=1, st_ready=1, no further writes after release.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared memory-access encodings for load and store paths
package store_buffer_pkg;

    localparam logic [2:0] MEMW_SB = 3'b001;
    localparam logic [2:0] MEMW_SH = 3'b010;
    localparam logic [2:0] MEMW_SW = 3'b011;

    localparam logic [3:0] WEN_NONE = 4'b0000;
    localparam logic [3:0] WEN_ALL  = 4'b1111;

    // Load encodings used by the MEM-stage extractor; kept here so both sides agree.
    typedef enum logic [2:0] {
        MEMR_NONE = 3'b000,
        MEMR_LB   = 3'b001,
        MEMR_LBU  = 3'b010,
        MEMR_LH   = 3'b011,
        MEMR_LHU  = 3'b100,
        MEMR_LW   = 3'b101
    } memr_e;

endpackage

// File: rtl/store_fmt.sv
// rtl/store_fmt.sv - combinational store lane formatter and alignment check
module store_fmt
    import store_buffer_pkg::*;
(
    input  logic [2:0]  memW,
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    output logic        is_store,
    output logic [3:0]  wen,
    output logic [31:0] wdata,
    output logic        misalign
);

    always_comb begin
        is_store = 1'b0;
        wen      = WEN_NONE;
        wdata    = 32'h0;
        misalign = 1'b0;
        case (memW)
            MEMW_SB: begin
                is_store = 1'b1;
                wen      = 4'b0001 << addr;
                wdata    = {4{data[7:0]}};
            end
            MEMW_SH: begin
                is_store = 1'b1;
                wen      = addr[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{data[15:0]}};
                misalign = addr[0];
            end
            MEMW_SW: begin
                is_store = 1'b1;
                wen      = WEN_ALL;
                wdata    = data;
                misalign = (addr != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store queue draining to the data SRAM port
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [2:0]  memW,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_misalign,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic        sb_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [29:0]      entry_addr  [DEPTH];
    logic [3:0]       entry_wen   [DEPTH];
    logic [31:0]      entry_wdata [DEPTH];
    logic [DEPTH-1:0] entry_valid;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic        fmt_is_store;
    logic [3:0]  fmt_wen;
    logic [31:0] fmt_wdata;
    logic        fmt_misalign;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        unused_ld_lo;

    store_fmt u_fmt (
        .memW     (memW),
        .addr     (st_addr[1:0]),
        .data     (st_data),
        .is_store (fmt_is_store),
        .wen      (fmt_wen),
        .wdata    (fmt_wdata),
        .misalign (fmt_misalign)
    );

    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    assign st_ready    = !full;
    assign sb_empty    = empty;
    assign st_misalign = st_valid & fmt_misalign;

    // Misaligned requests are consumed by the handshake but never stored.
    assign push = st_valid & st_ready & fmt_is_store & !fmt_misalign;
    assign pop  = data_sram_en & data_sram_addr_ok;

    assign data_sram_en    = !empty;
    assign data_sram_wen   = empty ? WEN_NONE : entry_wen[head];
    assign data_sram_addr  = empty ? 32'h0 : {entry_addr[head], 2'b00};
    assign data_sram_wdata = empty ? 32'h0 : entry_wdata[head];

    // Only already-queued entries are compared; the incoming request is not forwarded.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_addr[i] == ld_addr[31:2])) begin
                ld_hit = 1'b1;
            end
        end
    end

    assign unused_ld_lo = ^ld_addr[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            entry_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_addr[i]  <= '0;
                entry_wen[i]   <= '0;
                entry_wdata[i] <= '0;
            end
        end else begin
            if (push) begin
                entry_addr[tail]  <= st_addr[31:2];
                entry_wen[tail]   <= fmt_wen;
                entry_wdata[tail] <= fmt_wdata;
                entry_valid[tail] <= 1'b1;
                tail              <= tail + 1'b1;
            end
            if (pop) begin
                entry_valid[head] <= 1'b0;
                head              <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [2:0]  memW;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_misalign;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic        sb_empty;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .st_valid          (st_valid),
        .st_ready          (st_ready),
        .memW              (memW),
        .st_addr           (st_addr),
        .st_data           (st_data),
        .st_misalign       (st_misalign),
        .data_sram_en      (data_sram_en),
        .data_sram_wen     (data_sram_wen),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .ld_addr           (ld_addr),
        .ld_hit            (ld_hit),
        .sb_empty          (sb_empty)
    );

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        st_valid = 1'b0; memW = 3'b000; st_addr = 32'h0; st_data = 32'h0;
        data_sram_addr_ok = 1'b0; ld_addr = 32'h0;
        #3;
        n_tests++;
        if ({st_ready, sb_empty, data_sram_en, data_sram_wen, ld_hit} !== {1'b1, 1'b1, 1'b0, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ready=%b empty=%b en=%b wen=%b hit=%b, want 1 1 0 0000 0",
                     st_ready, sb_empty, data_sram_en, data_sram_wen, ld_hit);
        end
        n_tests++;
        if ({data_sram_addr, data_sram_wdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h wdata=%h, want 0 0", data_sram_addr, data_sram_wdata);
        end
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_sb();
        data_sram_addr_ok = 1'b1;
        st_valid = 1'b1; memW = 3'b001; st_addr = 32'h1000_0003; st_data = 32'h1234_56AB;
        #1;
        n_tests++;
        if (st_misalign !== 1'b0 || st_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_accept: got misalign=%b ready=%b, want 0 1", st_misalign, st_ready);
        end
        cyc();
        st_valid = 1'b0;
        #1;
        n_tests++;
        if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !== {1'b1, 4'b1000, 32'h1000_0000, 32'hABAB_ABAB}) begin
            n_fail++;
            $display("FAIL sb_fmt: got en=%b wen=%b addr=%h wdata=%h, want 1 1000 10000000 abababab",
                     data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata);
        end
        cyc();
        #1;
        n_tests++;
        if (data_sram_en !== 1'b0 || sb_empty !== 1'b1 || data_sram_wen !== 4'b0000) begin
            n_fail++;
            $display("FAIL sb_drain: got en=%b empty=%b wen=%b, want 0 1 0000", data_sram_en, sb_empty, data_sram_wen);
        end
    endtask

    task automatic test_sh_misalign();
        data_sram_addr_ok = 1'b0;
        st_valid = 1'b1; memW = 3'b010; st_addr = 32'h0000_0042; st_data = 32'hFFFF_BEEF;
        cyc();
        st_valid = 1'b0;
        #1;
        n_tests++;
        if ({data_sram_wen, data_sram_addr, data_sram_wdata} !== {4'b1100, 32'h0000_0040, 32'hBEEF_BEEF}) begin
            n_fail++;
            $display("FAIL sh_fmt: got wen=%b addr=%h wdata=%h, want 1100 00000040 beefbeef",
                     data_sram_wen, data_sram_addr, data_sram_wdata);
        end
        data_sram_addr_ok = 1'b1;
        cyc();
        data_sram_addr_ok = 1'b0;
        st_valid = 1'b1; memW = 3'b010; st_addr = 32'h0000_0041;
        #1;
        n_tests++;
        if (st_misalign !== 1'b1) begin
            n_fail++;
            $display("FAIL sh_misalign: got %b, want 1", st_misalign);
        end
        cyc();
        memW = 3'b011; st_addr = 32'h0000_0042;
        #1;
        n_tests++;
        if (st_misalign !== 1'b1 || sb_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_misalign: got misalign=%b empty=%b, want 1 1", st_misalign, sb_empty);
        end
        cyc();
        memW = 3'b000; st_addr = 32'h0000_0041;
        #1;
        n_tests++;
        if (st_misalign !== 1'b0 || sb_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL nonstore: got misalign=%b empty=%b, want 0 1", st_misalign, sb_empty);
        end
        cyc();
        st_valid = 1'b0;
        #1;
        n_tests++;
        if (sb_empty !== 1'b1 || data_sram_en !== 1'b0) begin
            n_fail++;
            $display("FAIL no_enqueue: got empty=%b en=%b, want 1 0", sb_empty, data_sram_en);
        end
    endtask

    task automatic test_full();
        data_sram_addr_ok = 1'b0;
        st_valid = 1'b1; memW = 3'b011; st_addr = 32'h0000_0100; st_data = 32'h1111_1111;
        cyc();
        st_addr = 32'h0000_0104; st_data = 32'h2222_2222;
        #1;
        n_tests++;
        if (st_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_one: got ready=%b, want 1", st_ready);
        end
        cyc();
        st_addr = 32'h0000_0108; st_data = 32'h3333_3333;
        #1;
        n_tests++;
        if (st_ready !== 1'b0 || data_sram_en !== 1'b1 || data_sram_addr !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL full_two: got ready=%b en=%b addr=%h, want 0 1 00000100", st_ready, data_sram_en, data_sram_addr);
        end
        cyc();
        #1;
        n_tests++;
        if (st_ready !== 1'b0 || data_sram_addr !== 32'h0000_0100 || data_sram_wdata !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL full_hold: got ready=%b addr=%h wdata=%h, want 0 00000100 11111111",
                     st_ready, data_sram_addr, data_sram_wdata);
        end
        data_sram_addr_ok = 1'b1;
        cyc();
        #1;
        n_tests++;
        if (st_ready !== 1'b1 || data_sram_addr !== 32'h0000_0104 || data_sram_wdata !== 32'h2222_2222) begin
            n_fail++;
            $display("FAIL full_pop1: got ready=%b addr=%h wdata=%h, want 1 00000104 22222222",
                     st_ready, data_sram_addr, data_sram_wdata);
        end
        cyc();
        st_valid = 1'b0;
        #1;
        n_tests++;
        if (data_sram_en !== 1'b1 || data_sram_addr !== 32'h0000_0108 || data_sram_wdata !== 32'h3333_3333) begin
            n_fail++;
            $display("FAIL full_third: got en=%b addr=%h wdata=%h, want 1 00000108 33333333",
                     data_sram_en, data_sram_addr, data_sram_wdata);
        end
        cyc();
        #1;
        n_tests++;
        if (sb_empty !== 1'b1 || data_sram_en !== 1'b0 || st_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_done: got empty=%b en=%b ready=%b, want 1 0 1", sb_empty, data_sram_en, st_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        data_sram_addr_ok = 1'b1;
        memW = 3'b011;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                st_valid = 1'b1;
                st_addr  = 32'h3000_0000 + 32'(i * 4);
                st_data  = 32'hA5A5_0000 + 32'(i);
            end else begin
                st_valid = 1'b0;
            end
            if (i > 0) begin
                exp_addr = 32'h3000_0000 + 32'((i - 1) * 4);
                exp_data = 32'hA5A5_0000 + 32'(i - 1);
                #1;
                n_tests++;
                if (data_sram_en !== 1'b1 || data_sram_addr !== exp_addr || data_sram_wdata !== exp_data || st_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: got en=%b addr=%h wdata=%h ready=%b, want 1 %h %h 1",
                             i - 1, data_sram_en, data_sram_addr, data_sram_wdata, st_ready, exp_addr, exp_data);
                end
            end
            cyc();
        end
        #1;
        n_tests++;
        if (sb_empty !== 1'b1 || data_sram_en !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got empty=%b en=%b, want 1 0", sb_empty, data_sram_en);
        end
    endtask

    task automatic test_ld_hit();
        data_sram_addr_ok = 1'b0;
        st_valid = 1'b1; memW = 3'b011; st_addr = 32'h2000_0004; st_data = 32'hCAFE_F00D;
        ld_addr = 32'h2000_0006;
        #1;
        n_tests++;
        if (ld_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_inflight: got %b, want 0", ld_hit);
        end
        cyc();
        st_valid = 1'b0;
        #1;
        n_tests++;
        if (ld_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL hit_match: got %b, want 1", ld_hit);
        end
        ld_addr = 32'h2000_0008;
        #1;
        n_tests++;
        if (ld_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_other: got %b, want 0", ld_hit);
        end
        data_sram_addr_ok = 1'b1;
        cyc();
        ld_addr = 32'h2000_0006;
        #1;
        n_tests++;
        if (ld_hit !== 1'b0 || sb_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL hit_drained: got hit=%b empty=%b, want 0 1", ld_hit, sb_empty);
        end
    endtask

    task automatic test_reset_mid();
        data_sram_addr_ok = 1'b0;
        st_valid = 1'b1; memW = 3'b011; st_addr = 32'h4000_0000; st_data = 32'h5555_5555;
        cyc();
        st_addr = 32'h4000_0004; st_data = 32'h6666_6666;
        cyc();
        st_valid = 1'b0;
        #1;
        n_tests++;
        if (data_sram_en !== 1'b1 || st_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pre: got en=%b ready=%b, want 1 0", data_sram_en, st_ready);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !== 69'h0 ||
            sb_empty !== 1'b1 || st_ready !== 1'b1 || ld_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got en=%b wen=%b addr=%h wdata=%h empty=%b ready=%b, want 0 0000 0 0 1 1",
                     data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, sb_empty, st_ready);
        end
        #1;
        reset = 1'b0;
        data_sram_addr_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            #1;
            n_tests++;
            if (data_sram_en !== 1'b0 || sb_empty !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_after_%0d: got en=%b empty=%b, want 0 1", i, data_sram_en, sb_empty);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sb();
        test_sh_misalign();
        test_full();
        test_back_to_back();
        test_ld_hit();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
